// File: rtl/fft16_out_unloader.sv
// Collects 16-point FFT result pairs in any bin order into two ping-pong banks
// and streams each completed frame out in natural bin order over valid/ready.
module fft16_out_unloader #(
  parameter int NBITS = 16,
  parameter int NPTS  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [3:0]       in_idx_x,
  input  logic [3:0]       in_idx_y,
  input  logic [NBITS-1:0] Xr,
  input  logic [NBITS-1:0] Xi,
  input  logic [NBITS-1:0] Yr,
  input  logic [NBITS-1:0] Yi,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out_re,
  output logic [NBITS-1:0] out_im,
  output logic [3:0]       out_idx,
  output logic             out_last,
  output logic             dup_err
);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_e;

  bank_st_e          st_q   [2];
  bank_st_e          st_d   [2];
  logic [NPTS-1:0]   mask_q [2];
  logic [NPTS-1:0]   mask_d [2];
  logic              wb_q, wb_d, rb_q, rb_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              dup_q, dup_d;
  logic [2*NBITS-1:0] mem_q [2][NPTS];

  logic              acc, pop;
  logic [NPTS-1:0]   set_bits, mask_new;
  logic [2*NBITS-1:0] rd_word;

  assign in_rdy   = (st_q[wb_q] == EMPTY) || (st_q[wb_q] == FILLING);
  assign acc      = in_vld && in_rdy;
  assign out_vld  = (st_q[rb_q] == DRAINING);
  assign pop      = out_vld && out_rdy;
  assign set_bits = (NPTS'(1) << in_idx_x) | (NPTS'(1) << in_idx_y);
  assign mask_new = mask_q[wb_q] | set_bits;

  // Data is gated so idle/reset outputs read as zero regardless of buffer contents
  assign rd_word  = mem_q[rb_q][cnt_q];
  assign out_re   = out_vld ? rd_word[2*NBITS-1:NBITS] : '0;
  assign out_im   = out_vld ? rd_word[NBITS-1:0]       : '0;
  assign out_idx  = out_vld ? cnt_q : 4'd0;
  assign out_last = out_vld && (cnt_q == 4'(NPTS-1));
  assign dup_err  = dup_q;

  // Read side only touches FULL/DRAINING banks, write side only EMPTY/FILLING,
  // so both halves can update st_d/mask_d in the same cycle without conflict.
  always_comb begin
    st_d   = st_q;
    mask_d = mask_q;
    wb_d   = wb_q;
    rb_d   = rb_q;
    cnt_d  = cnt_q;
    dup_d  = 1'b0;

    if (st_q[rb_q] == FULL) begin
      st_d[rb_q] = DRAINING;
      cnt_d      = '0;
    end else if (pop) begin
      if (cnt_q == 4'(NPTS-1)) begin
        mask_d[rb_q] = '0;
        st_d[rb_q]   = EMPTY;
        rb_d         = !rb_q;
        cnt_d        = '0;
        // Chain straight into the other bank so back-to-back frames have no bubble
        if (st_q[!rb_q] == FULL) st_d[!rb_q] = DRAINING;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end

    if (acc) begin
      dup_d = (in_idx_x == in_idx_y) || mask_q[wb_q][in_idx_x] || mask_q[wb_q][in_idx_y];
      mask_d[wb_q] = mask_new;
      if (&mask_new) begin
        st_d[wb_q] = FULL;
        wb_d       = !wb_q;
      end else begin
        st_d[wb_q] = FILLING;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        st_q[b]   <= EMPTY;
        mask_q[b] <= '0;
      end
      wb_q  <= 1'b0;
      rb_q  <= 1'b0;
      cnt_q <= '0;
      dup_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      mask_q <= mask_d;
      wb_q   <= wb_d;
      rb_q   <= rb_d;
      cnt_q  <= cnt_d;
      dup_q  <= dup_d;
    end
  end

  // Storage needs no reset: the masks decide what is valid. Y is written last so it wins on equal indices.
  always_ff @(posedge clk) begin
    if (acc) begin
      mem_q[wb_q][in_idx_x] <= {Xr, Xi};
      mem_q[wb_q][in_idx_y] <= {Yr, Yi};
    end
  end

endmodule

// File: tb/tb_fft16_out_unloader.sv
// Bench for fft16_out_unloader: directed sequences, a collision vector table and
// randomized frames under backpressure, all checked against a frame-level model.
module tb_fft16_out_unloader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_vld, in_rdy, out_vld, out_rdy, out_last, dup_err;
  logic [3:0]  in_idx_x, in_idx_y, out_idx;
  logic [15:0] Xr, Xi, Yr, Yi, out_re, out_im;

  fft16_out_unloader #(.NBITS(16), .NPTS(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_idx_x(in_idx_x), .in_idx_y(in_idx_y), .Xr(Xr), .Xi(Xi), .Yr(Yr), .Yi(Yi),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .out_last(out_last), .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [3:0] idx; logic [15:0] re; logic [15:0] im; } word_t;
  word_t       exp_q[$];
  logic [15:0] fre [16];
  logic [15:0] fim [16];
  logic [15:0] fmask;
  logic        dup_pend, held;
  logic [37:0] held_val;
  int          run, max_run;
  logic        saw_rdy0;

  function automatic int pending_frames();
    return (exp_q.size() + 15) / 16;
  endfunction

  initial begin
    fmask = '0; dup_pend = 1'b0; held = 1'b0; held_val = '0;
    run = 0; max_run = 0; saw_rdy0 = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        fmask = '0; dup_pend = 1'b0; held = 1'b0; run = 0;
      end else begin
        word_t e;
        chk("dup_err", dup_err, dup_pend);
        chk("in_rdy", in_rdy, pending_frames() < 2);
        if (!in_rdy) saw_rdy0 = 1'b1;
        if (out_vld) run++; else run = 0;
        if (run > max_run) max_run = run;
        if (held) chk("hold_stable", {out_vld, out_last, out_idx, out_re, out_im}, held_val);
        if (!out_vld) chk("last_idle", out_last, 1'b0);
        if (out_vld) chk("vld_has_data", exp_q.size() > 0, 1'b1);
        if (out_vld && out_rdy && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_word", {out_idx, out_re, out_im, out_last},
              {e.idx, e.re, e.im, e.idx == 4'd15});
        end
        held     = out_vld && !out_rdy;
        held_val = {out_vld, out_last, out_idx, out_re, out_im};
        dup_pend = 1'b0;
        if (in_vld && in_rdy) begin
          dup_pend = (in_idx_x == in_idx_y) || fmask[in_idx_x] || fmask[in_idx_y];
          fre[in_idx_x] = Xr; fim[in_idx_x] = Xi;
          fre[in_idx_y] = Yr; fim[in_idx_y] = Yi;
          fmask[in_idx_x] = 1'b1;
          fmask[in_idx_y] = 1'b1;
          if (&fmask) begin
            for (int i = 0; i < 16; i++) begin
              e.idx = 4'(i); e.re = fre[i]; e.im = fim[i];
              exp_q.push_back(e);
            end
            fmask = '0;
          end
        end
      end
    end
  end

  // ---------------- out_rdy driver ----------------
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled
  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = 1'($urandom % 2);
        default: out_rdy = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_pair(input logic [3:0] x, input logic [3:0] y,
                           input logic [15:0] xr, input logic [15:0] xi,
                           input logic [15:0] yr, input logic [15:0] yi);
    int n;
    n = 0;
    in_vld = 1'b1; in_idx_x = x; in_idx_y = y; Xr = xr; Xi = xi; Yr = yr; Yi = yi;
    forever begin
      @(negedge clk);
      if (in_rdy) break;
      n++;
      if (n > 300) begin chk("in_rdy_timeout", 1'b0, 1'b1); break; end
    end
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic send_linear(input logic [15:0] off);
    for (int k = 0; k < 8; k++)
      send_pair(4'(2*k), 4'(2*k+1), 16'(k) + off, 16'(k) ^ 16'h00a5,
                16'h0100 + 16'(k) + off, 16'h0200 + 16'(k));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_vld) break;
      n++;
      if (n > 600) begin chk("drain_timeout", 1'b0, 1'b1); break; end
    end
  endtask

  task automatic send_random_frame();
    int perm[16];
    int j, t, gap;
    for (int i = 0; i < 16; i++) perm[i] = i;
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int k = 0; k < 8; k++) begin
      send_pair(4'(perm[2*k]), 4'(perm[2*k+1]), 16'($urandom), 16'($urandom),
                16'($urandom), 16'($urandom));
      gap = $urandom_range(2, 0);
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  // ---------------- collision vector table ----------------
  typedef struct {
    logic [3:0]  x, y;
    logic [15:0] xr, xi, yr, yi;
    logic        dup;
  } vec_t;
  vec_t tbl[9];

  initial begin
    tbl[0] = '{4'd0,  4'd1,  16'h3000, 16'h4000, 16'h5000, 16'h6000, 1'b0};
    tbl[1] = '{4'd5,  4'd5,  16'h3001, 16'h4001, 16'h5001, 16'h6001, 1'b1};
    tbl[2] = '{4'd2,  4'd3,  16'h3002, 16'h4002, 16'h5002, 16'h6002, 1'b0};
    tbl[3] = '{4'd3,  4'd4,  16'h3003, 16'h4003, 16'h5003, 16'h6003, 1'b1};
    tbl[4] = '{4'd6,  4'd7,  16'h3004, 16'h4004, 16'h5004, 16'h6004, 1'b0};
    tbl[5] = '{4'd8,  4'd9,  16'h3005, 16'h4005, 16'h5005, 16'h6005, 1'b0};
    tbl[6] = '{4'd10, 4'd11, 16'h3006, 16'h4006, 16'h5006, 16'h6006, 1'b0};
    tbl[7] = '{4'd12, 4'd13, 16'h3007, 16'h4007, 16'h5007, 16'h6007, 1'b0};
    tbl[8] = '{4'd14, 4'd15, 16'h3008, 16'h4008, 16'h5008, 16'h6008, 1'b0};
  end

  // ---------------- main sequence ----------------
  int bitrev[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  initial begin
    rst_n = 1'b0; in_vld = 1'b0; in_idx_x = '0; in_idx_y = '0;
    Xr = '0; Xi = '0; Yr = '0; Yi = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {out_vld, out_re, out_im, out_idx, out_last, dup_err}, '0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", in_rdy, 1'b1);
    @(posedge clk); #1;

    // Natural-order frame with first-word latency check
    send_linear(16'h0000);
    @(negedge clk); chk("vld_lat0", out_vld, 1'b0);
    @(negedge clk); chk("vld_lat1", out_vld, 1'b1);
    wait_drain();
    @(posedge clk); #1;

    // Bit-reversed pair order
    for (int k = 0; k < 8; k++)
      send_pair(4'(bitrev[k]), 4'(bitrev[k] + 8), 16'h0700 + 16'(bitrev[k]), 16'h0070,
                16'h0800 + 16'(bitrev[k] + 8), 16'h0080);
    wait_drain();
    @(posedge clk); #1;

    // Back-to-back frames: continuous 32-word output, input stalls
    max_run = 0; saw_rdy0 = 1'b0;
    send_linear(16'h1000);
    send_linear(16'h2000);
    wait_drain();
    chk("b2b_run", 64'(max_run), 64'd32);
    chk("b2b_rdy_drop", saw_rdy0, 1'b1);
    @(posedge clk); #1;

    // Collisions from the vector table
    for (int i = 0; i < 9; i++) begin
      send_pair(tbl[i].x, tbl[i].y, tbl[i].xr, tbl[i].xi, tbl[i].yr, tbl[i].yi);
      @(negedge clk); chk("tbl_dup", dup_err, tbl[i].dup);
      if (i == 7) begin
        repeat (3) @(negedge clk);
        chk("no_early_frame", out_vld, 1'b0);
      end
      @(posedge clk); #1;
    end
    wait_drain();
    @(posedge clk); #1;

    // Randomized frames under random backpressure
    rdy_mode = 1;
    for (int f = 0; f < 4; f++) send_random_frame();
    wait_drain();
    rdy_mode = 0;
    @(posedge clk); #1;

    // Reset mid-frame: one stalled full frame plus a partial one are discarded
    rdy_mode = 2;
    send_linear(16'h4000);
    for (int k = 0; k < 4; k++)
      send_pair(4'(2*k), 4'(2*k+1), 16'h5000, 16'h5001, 16'h5002, 16'h5003);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_outs", {out_vld, out_re, out_im, out_idx, out_last, dup_err}, '0);
    @(posedge clk); #1; rst_n = 1'b1; rdy_mode = 0;
    @(negedge clk);
    chk("midrst_rdy", in_rdy, 1'b1);
    @(posedge clk); #1;
    send_linear(16'h6000);
    wait_drain();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("no_partial", fmask, 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft16_out_unloader.md
# fft16_out_unloader

Output-side collector for the 16-point FFT datapath. It accepts final-stage butterfly result pairs (X, Y) tagged with their frequency-bin indices in any order, stores them in a two-bank ping-pong buffer, and streams each completed frame out in natural bin order (0..15) over a valid/ready interface. Data words are opaque NBITS-bit half-precision values; no arithmetic is performed on them.

## Interface
- NBITS, 16, width of each real/imaginary word
- NPTS, 16, frame length (fixed at 16; index width 4)
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- in_vld  in  1  result pair valid
- in_rdy  out  1  unloader can accept a pair this cycle
- in_idx_x  in  4  bin index for X
- in_idx_y  in  4  bin index for Y
- Xr, Xi, Yr, Yi  in  NBITS each  butterfly results
- out_vld  out  1  output word valid
- out_rdy  in  1  downstream accepts word
- out_re, out_im  out  NBITS each  bin value
- out_idx  out  4  bin index of current word
- out_last  out  1  high with bin 15
- dup_err  out  1  one-cycle pulse on an index collision

## Operation
- Two banks (0/1), each: 16×2×NBITS storage plus a 16-bit written mask and a state: EMPTY, FILLING, FULL, DRAINING.
- Write pointer wb and read pointer rb, both reset to 0.
- in_rdy = (state[wb] is EMPTY or FILLING). It is combinational from registered state.
- Accept when in_vld && in_rdy: write {Xr,Xi} at in_idx_x, then {Yr,Yi} at in_idx_y, and set both mask bits. An EMPTY bank becomes FILLING.
- Collisions: dup_err pulses the next cycle if in_idx_x == in_idx_y, or if either target mask bit is already set. When the two indices are equal, Y wins. An already-set entry is overwritten. The pulse is one cycle per offending accept.
- When the mask becomes all ones after an accept, the bank goes to FULL and wb toggles.
- Read side: when state[rb] == FULL, go to DRAINING, clear the read counter, and assert out_vld.
- During DRAINING:
  - out_re/out_im are the stored entry at the read counter; out_idx equals the counter.
  - The word advances on out_vld && out_rdy.
  - out_last = out_vld && counter == 15.
  - When the last word is accepted: clear the bank mask, set the bank to EMPTY, toggle rb, deassert out_vld (unless the other bank is already FULL; see Timing).
- Output data, out_idx and out_last stay stable while out_vld && !out_rdy.
- Both banks can be busy at once: one FILLING while the other is DRAINING or FULL. When both banks are FULL or DRAINING, in_rdy = 0.
- Reset value of every output:
  - out_vld=0, out_re=0, out_im=0, out_idx=0, out_last=0, dup_err=0.
  - in_rdy=1 from the first cycle after rst_n deasserts.
  - Both masks are cleared and both states are EMPTY.
- Reset mid-frame discards all stored data in both banks. No partial frame is emitted.

## Timing
- A write is captured on the accepting edge.
- If the accepting pair completes the frame, out_vld rises on the next edge (latency 1 cycle), provided rb points at that bank.
- Drain takes exactly 16 cycles with out_rdy held high. out_vld is continuous across back-to-back frames: if the other bank is FULL when bin 15 is accepted, the next cycle shows bin 0 of that bank with no bubble.
- Simultaneous events:
  - A completing write to bank wb and the last-word accept from bank rb in the same cycle both take effect. The toggled rb then selects the newly FULL bank.
  - A write to a bank in the same cycle its drain finishes cannot occur, because in_rdy is 0 for non-EMPTY/FILLING banks.
- Sustained throughput: 1 pair per cycle in, 1 word per cycle out. A frame is 8 pairs in and 16 words out, so input stalls about 8 of every 16 cycles under continuous load.

## Test plan
- Reset, then 8 pairs (x=2k, y=2k+1, Xr=k, Yr=0x100+k), out_rdy=1:
  - out_vld rises 1 cycle after the 8th accept.
  - out_idx runs 0..15 with out_re = k / 0x100+k as written.
  - out_last is high only on idx 15. dup_err never fires.
- Same frame in bit-reversed pair order (0/8, 4/12, 2/10, ...): output is still in natural order 0..15 with matching data.
- Two frames back-to-back, out_rdy=1:
  - The second frame fills during the first drain.
  - out_vld stays high for 32 consecutive cycles.
  - in_rdy drops once both banks are occupied.
- Backpressure: toggle out_rdy pseudo-randomly. Every held word keeps out_re/out_im/out_idx/out_last unchanged until accepted, and no bin is lost or repeated.
- Collision: a pair with x=y=5, then a pair rewriting bin 3:
  - dup_err pulses once for each pair.
  - Bin 5 holds the Y data and bin 3 holds the latest data.
  - The frame completes only after all 16 bins are set.
- Assert rst_n low after 4 pairs, release, then send a full frame:
  - All outputs are 0 during reset and in_rdy=1 after release.
  - Only the new frame is emitted.
